// File: rtl/mem_responder.sv
// mem_responder
//   Word-addressed memory that answers the cache's memory-side handshake:
//   read_mem/write_mem -> grant_mem -> address (and write data) -> ready_mem.
//   The access latency is set by WAIT_STATES. A sticky proto_err flag records
//   handshake violations.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   read_mem     read request from the cache
//   write_mem    write request from the cache
//   grant_mem    bus granted to the requester (registered)
//   ready_mem    access complete (registered)
//   mem_adbus    byte address, valid from the cycle after grant_mem rises
//   mem_databus  write data from the cache, or read data driven in READY
//   proto_err    sticky protocol-violation flag, cleared only by reset
module mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int ASIZE       = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_mem,
  input  logic        write_mem,
  output logic        grant_mem,
  output logic        ready_mem,
  input  logic [31:0] mem_adbus,
  inout  wire  [31:0] mem_databus,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, READY} state_t;

  // The counter is loaded with WAIT_STATES-1 so that WAIT lasts exactly
  // WAIT_STATES edges, including the final edge that enters READY.
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t           state_reg;
  logic             op_write_reg;
  logic [3:0]       cnt_reg;
  logic [ASIZE-1:0] idx_reg;
  logic [31:0]      wdata_reg;
  logic [31:0]      rdata_reg;
  logic             drive_reg;
  logic             grant_reg;
  logic             ready_reg;
  logic             err_reg;

  logic [31:0]      mem [DEPTH];

  // Only the word index is decoded. The byte-lane bits and the bits above
  // the index are dropped, so high addresses alias onto the array.
  logic [ASIZE-1:0] bus_idx;
  logic             unused_addr_bits;
  assign bus_idx          = mem_adbus[ASIZE+1:2];
  assign unused_addr_bits = ^{mem_adbus[1:0], mem_adbus[31:ASIZE+2]};

  // The request line that started this transaction must stay high until release.
  logic req_held;
  assign req_held = op_write_reg ? write_mem : read_mem;

  // Edge on which the FSM enters READY. With no wait states, this is the
  // ADDR edge, so the write commit takes address and data straight off the bus.
  logic enter_ready_from_addr;
  logic enter_ready_from_wait;
  logic commit_en;
  logic [ASIZE-1:0] commit_idx;
  logic [31:0]      commit_data;
  logic             rd_en;

  assign enter_ready_from_addr = (state_reg == ADDR) && (WAIT_STATES == 0) && req_held;
  assign enter_ready_from_wait = (state_reg == WAIT) && (cnt_reg == 4'd0) && req_held;
  assign commit_en   = op_write_reg && (enter_ready_from_addr || enter_ready_from_wait);
  assign commit_idx  = (state_reg == ADDR) ? bus_idx : idx_reg;
  assign commit_data = (state_reg == ADDR) ? mem_databus : wdata_reg;
  assign rd_en       = (state_reg == ADDR) && !op_write_reg;

  // The array has no reset. Its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (commit_en) begin
      mem[commit_idx] <= commit_data;
    end
    if (rd_en) begin
      rdata_reg <= mem[bus_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_write_reg <= 1'b0;
      cnt_reg      <= 4'd0;
      idx_reg      <= '0;
      wdata_reg    <= 32'd0;
      drive_reg    <= 1'b0;
      grant_reg    <= 1'b0;
      ready_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (read_mem || write_mem) begin
            op_write_reg <= write_mem;  // write wins when both are raised
            if (read_mem && write_mem) begin
              err_reg <= 1'b1;
            end
            grant_reg <= 1'b1;
            state_reg <= ADDR;
          end
        end
        ADDR: begin
          if (!req_held) begin
            err_reg   <= 1'b1;
            grant_reg <= 1'b0;
            state_reg <= IDLE;
          end else begin
            idx_reg   <= bus_idx;
            wdata_reg <= mem_databus;
            if (WAIT_STATES == 0) begin
              ready_reg <= 1'b1;
              drive_reg <= !op_write_reg;
              state_reg <= READY;
            end else begin
              cnt_reg   <= CNT_LOAD;
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req_held) begin
            err_reg   <= 1'b1;
            grant_reg <= 1'b0;
            state_reg <= IDLE;
          end else if (cnt_reg == 4'd0) begin
            ready_reg <= 1'b1;
            drive_reg <= !op_write_reg;
            state_reg <= READY;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        READY: begin
          if (!req_held) begin
            ready_reg <= 1'b0;
            grant_reg <= 1'b0;
            drive_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant_mem   = grant_reg;
  assign ready_mem   = ready_reg;
  assign proto_err   = err_reg;
  assign mem_databus = drive_reg ? rdata_reg : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   The bench drives directed and random memory transactions into mem_responder.
//   Each read pushes its expected word, taken from a word-indexed reference model,
//   into a queue. A monitor pops that word and compares it when ready_mem rises
//   on a read.
module tb_mem_responder;
  localparam int WS    = 2;
  localparam int DEPTH = 1024;
  localparam int ASIZE = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_mem = 1'b0;
  logic        write_mem = 1'b0;
  logic [31:0] mem_adbus = 32'd0;
  wire  [31:0] mem_databus;
  logic        grant_mem;
  logic        ready_mem;
  logic        proto_err;

  logic        tb_drive = 1'b0;
  logic [31:0] tb_data = 32'd0;
  assign mem_databus = tb_drive ? tb_data : 32'hzzzz_zzzz;

  mem_responder #(.DEPTH(DEPTH), .ASIZE(ASIZE), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .read_mem(read_mem), .write_mem(write_mem),
    .grant_mem(grant_mem), .ready_mem(ready_mem), .mem_adbus(mem_adbus),
    .mem_databus(mem_databus), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  bit   [31:0] model[int];
  logic [31:0] addrs[$];
  bit          mon_is_read = 1'b0;
  logic        ready_prev = 1'b0;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(DEPTH));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: when ready_mem rises on a read, compare the bus with the queue head.
  always @(negedge clk) begin
    if (ready_mem && !ready_prev && mon_is_read) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got %h expected no response", mem_databus);
      end else begin
        chk("rd_data", mem_databus, exp_q.pop_front());
      end
    end
    ready_prev <= ready_mem;
  end

  // mode 0: normal, 1: drop request in WAIT, 2: reset while in READY.
  // The caller is 1 time unit after a rising edge. The request goes up at once,
  // so back-to-back calls leave exactly one idle cycle.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int mode, input bit both);
    int n;
    mon_is_read = !wr;
    if (wr) write_mem = 1'b1; else read_mem = 1'b1;
    if (both) begin read_mem = 1'b1; write_mem = 1'b1; end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!grant_mem && n < 8);
    chk("grant_lat", 32'(n), 32'd1);
    if (!grant_mem) begin
      read_mem = 1'b0; write_mem = 1'b0;
      @(posedge clk); #1;
      return;
    end
    mem_adbus = addr;
    if (wr) begin tb_drive = 1'b1; tb_data = data; end
    if (mode == 1) begin
      @(posedge clk); #1;            // address edge, now in the wait period
      read_mem = 1'b0; write_mem = 1'b0;
      @(posedge clk); #1;
      chk1("drop_grant", grant_mem, 1'b0);
      chk1("drop_err", proto_err, 1'b1);
      chk1("drop_ready", ready_mem, 1'b0);
      tb_drive = 1'b0;
      $display("[TB] DROP %s addr=%h data=%h", wr ? "WR" : "RD", addr, data);
      return;
    end
    if (!wr) exp_q.push_back(model[widx(addr)]);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ready_mem && n < 40);
    chk("ready_lat", 32'(n), 32'(1 + WS));
    if (wr) model[widx(addr)] = data;
    if (mode == 2) begin
      @(negedge clk); #1;            // let the monitor see the read data first
      rst_n = 1'b0;
      #1;
      chk1("rst_ready", ready_mem, 1'b0);
      chk1("rst_grant", grant_mem, 1'b0);
      chk1("rst_err", proto_err, 1'b0);
      read_mem = 1'b0; write_mem = 1'b0; tb_drive = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("[TB] RST-ABORT %s addr=%h", wr ? "WR" : "RD", addr);
      return;
    end
    @(posedge clk); #1;
    chk1("ready_hold", ready_mem, 1'b1);
    read_mem = 1'b0; write_mem = 1'b0; tb_drive = 1'b0;
    @(posedge clk); #1;
    chk1("rel_ready", ready_mem, 1'b0);
    chk1("rel_grant", grant_mem, 1'b0);
    $display("[TB] %s addr=%h data=%h", wr ? "WR" : "RD", addr,
             wr ? data : model[widx(addr)]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    #2;
    chk1("reset_grant", grant_mem, 1'b0);
    chk1("reset_ready", ready_mem, 1'b0);
    chk1("reset_err", proto_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0);
    access(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0);
    access(1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 0, 1'b0);
    access(1'b0, 32'h0000_0004, 32'h0, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      access(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      access(1'b0, 32'(i * 4), 32'h0, 0, 1'b0);
    chk1("no_err_yet", proto_err, 1'b0);

    access(1'b1, 32'h0000_0020, 32'h1111_1111, 0, 1'b0);
    access(1'b1, 32'h0000_0020, 32'h2222_2222, 1, 1'b0);
    access(1'b0, 32'h0000_0020, 32'h0, 0, 1'b0);
    chk1("err_sticky", proto_err, 1'b1);

    access(1'b0, 32'h0000_0010, 32'h0, 2, 1'b0);

    access(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 0, 1'b1);
    chk1("both_err", proto_err, 1'b1);
    access(1'b0, 32'h0000_0030, 32'h0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if (addrs.size() == 0 || $urandom_range(1, 0) == 1) begin
        a = $urandom;
        d = $urandom;
        addrs.push_back(a);
        access(1'b1, a, d, 0, 1'b0);
      end else begin
        a = addrs[$urandom_range(addrs.size() - 1, 0)];
        access(1'b0, a, 32'h0, 0, 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
